// File: rtl/ram_burst_master_if.sv
// Command, write-beat and read-beat streams between the codec datapath and the RAM burst master.
interface ram_burst_master_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [17:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_err;

  logic             wr_valid;
  logic             wr_ready;
  logic [23:0]      wr_data;

  logic             rd_valid;
  logic             rd_ready;
  logic [23:0]      rd_data;
  logic             rd_last;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_len,
    input  cmd_ready, cmd_err,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data, rd_last,
    output rd_ready
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len,
    output cmd_ready, cmd_err,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data, rd_last,
    input  rd_ready
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for the 24-bit image RAM: drives registered A/WE/OE/D, captures Q one
// cycle after each launch and returns read beats through a 2-entry valid/ready buffer.
module ram_burst_master #(
  parameter int ADDR_LIMIT = 4096,
  parameter int LEN_W      = 8
) (
  input  logic              CK,
  input  logic              RST,
  ram_burst_master_if.slave bus,
  output logic              busy,
  output logic [17:0]       A,
  output logic              WE,
  output logic              OE,
  output logic [23:0]       D,
  input  logic [23:0]       Q
);
  localparam logic [17:0] LIMIT     = 18'(ADDR_LIMIT);
  localparam logic [17:0] LAST_ADDR = 18'(ADDR_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t state, state_nxt;

  logic [17:0]      addr;
  logic [LEN_W-1:0] beats;
  logic             inflight;
  logic             inflight_last;
  logic [24:0]      buf_mem [2];
  logic             wptr;
  logic             rptr;
  logic [1:0]       count;
  logic             cmd_err_q;

  logic        cmd_ready;
  logic        wr_ready;
  logic        cmd_fire;
  logic        cmd_bad;
  logic        wr_fire;
  logic        launch;
  logic        drain_done;
  logic        rd_valid;
  logic        pop;
  logic [2:0]  occ_next;
  logic [17:0] addr_inc;
  logic [24:0] head;

  assign cmd_bad  = bus.cmd_addr >= LIMIT;
  assign rd_valid = count != 2'd0;
  assign pop      = rd_valid & bus.rd_ready;
  // Buffer occupancy once this cycle's pop and pending capture settle; a new launch
  // needs a free slot for its capture one cycle later.
  assign occ_next = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign addr_inc = (addr == LAST_ADDR) ? 18'd0 : addr + 18'd1;
  assign head     = buf_mem[rptr];

  assign bus.cmd_ready = cmd_ready;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.wr_ready  = wr_ready;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = head[23:0];
  assign bus.rd_last   = rd_valid & head[24];
  assign busy          = state != IDLE;

  always_ff @(posedge CK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    cmd_fire   = 1'b0;
    wr_fire    = 1'b0;
    launch     = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        cmd_fire  = bus.cmd_valid;
        if (cmd_fire && !cmd_bad) state_nxt = bus.cmd_we ? WRITE : READ;
      end
      WRITE: begin
        wr_ready = 1'b1;
        wr_fire  = bus.wr_valid;
        if (wr_fire && beats == '0) state_nxt = IDLE;
      end
      READ: begin
        launch = occ_next < 3'd2;
        if (launch && beats == '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!inflight && count == 2'd0) begin
          drain_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      A             <= '0;
      WE            <= 1'b0;
      OE            <= 1'b0;
      D             <= '0;
      addr          <= '0;
      beats         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      cmd_err_q     <= 1'b0;
      buf_mem[0]    <= '0;
      buf_mem[1]    <= '0;
      wptr          <= 1'b0;
      rptr          <= 1'b0;
      count         <= 2'd0;
    end else begin
      cmd_err_q <= cmd_fire & cmd_bad;
      WE        <= wr_fire;
      inflight  <= launch;
      if (cmd_fire && !cmd_bad) begin
        addr  <= bus.cmd_addr;
        beats <= bus.cmd_len;
      end
      if (wr_fire) begin
        A     <= addr;
        D     <= bus.wr_data;
        addr  <= addr_inc;
        beats <= beats - 1'b1;
      end
      if (launch) begin
        A             <= addr;
        OE            <= 1'b1;
        addr          <= addr_inc;
        beats         <= beats - 1'b1;
        inflight_last <= beats == '0;
      end
      if (drain_done) OE <= 1'b0;
      // Q belongs to the address launched on the previous edge.
      if (inflight) begin
        buf_mem[wptr] <= {inflight_last, Q};
        wptr          <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule
